// File: rtl/synch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : synch_filter
//  Description : Multi-channel input synchronizer with a per-channel
//                stability filter, registered edge pulses and sticky
//                event flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module synch_filter #(
    parameter int               WIDTH     = 1,
    parameter int               STAGES    = 3,
    parameter int               FILTER    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               EVT_MODE  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] change,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] evt_sticky
);

    // FILTER values 0 and 1 both collapse to "accept on the first differing
    // synced cycle", so the terminal count is 0 and a 1-bit counter suffices.
    localparam int               CNT_W        = (FILTER > 2) ? $clog2(FILTER) : 1;
    localparam int               CNT_LAST_INT = (FILTER > 1) ? (FILTER - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CNT_LAST_INT);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] upd;

    logic [WIDTH-1:0] o_q,      o_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic [WIDTH-1:0] fall_q,   fall_d;
    logic [WIDTH-1:0] change_q, change_d;
    logic [WIDTH-1:0] sticky_q, sticky_d;
    logic [WIDTH-1:0] evt_set;

    // Synchronizer chain: i enters stage 0, the last stage is the synced value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= i;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[STAGES-1];

    // Per-channel stability counters; upd[k] marks the edge where o[k] flips.
    for (genvar k = 0; k < WIDTH; k++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             upd_bit;

        // Count consecutive differing cycles; any agreement restarts the count.
        always_comb begin
            cnt_d   = '0;
            upd_bit = 1'b0;
            if (s[k] != o_q[k]) begin
                if (cnt_q == CNT_LAST) begin
                    upd_bit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Counter register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign upd[k] = upd_bit;
    end

    // Next output level, edge pulses and sticky flags (set wins over clear).
    always_comb begin
        o_d      = (o_q & ~upd) | (s & upd);
        rise_d   = upd & s;
        fall_d   = upd & ~s;
        change_d = rise_d | fall_d;
        evt_set  = rise_d | fall_d;
        if (EVT_MODE == 0) begin
            evt_set = rise_d;
        end else if (EVT_MODE == 1) begin
            evt_set = fall_d;
        end
        sticky_d = (sticky_q & ~evt_clr) | evt_set;
    end

    // Output registers; pulses line up with the first cycle of the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_q      <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= '0;
            sticky_q <= '0;
        end else begin
            o_q      <= o_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
            sticky_q <= sticky_d;
        end
    end

    assign o          = o_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign change     = change_q;
    assign evt_sticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_synch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_synch_filter
//  Description : Scoreboard bench for synch_filter. DUT1: 4 channels,
//                3 stages, filter 4, either-edge events. DUT2: 1 channel,
//                2 stages, no filter, rise events.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_synch_filter;

    localparam int S1  = 3;
    localparam int F1  = 4;
    localparam int FP1 = (F1 > 1) ? F1 : 1;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;

    logic [3:0] i1 = 4'hF, clr1 = 4'h0;
    logic [3:0] o1, rise1, fall1, chg1, st1;
    logic [0:0] i2 = 1'b0, clr2 = 1'b0;
    logic [0:0] o2, rise2, fall2, chg2, st2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    synch_filter #(
        .WIDTH(4), .STAGES(S1), .FILTER(F1), .RESET_VAL(4'h0), .EVT_MODE(2)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .i(i1), .o(o1), .rise(rise1), .fall(fall1),
        .change(chg1), .evt_clr(clr1), .evt_sticky(st1)
    );

    synch_filter #(
        .WIDTH(1), .STAGES(2), .FILTER(0), .RESET_VAL(1'b0), .EVT_MODE(0)
    ) u_dut2 (
        .clk(clk), .reset_n(reset_n), .i(i2), .o(o2), .rise(rise2), .fall(fall2),
        .change(chg2), .evt_clr(clr2), .evt_sticky(st2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. DUT1: o[k] flips when the last FP1 synced samples
    // (input delayed S1 edges) all differ from the current o[k].
    // DUT2: o is simply the input delayed by 3 edges.
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    ev_t        sb[$];
    logic [3:0] hist1[$];
    logic [3:0] shist1[$];
    logic [0:0] h2[$];
    logic [3:0] m_o1 = '0, m_st1 = '0;
    logic [3:0] s_m, flip, r_m, f_m, junk4;
    logic [0:0] m_o2 = '0, m_st2 = '0, m_rise2 = '0, m_fall2 = '0, prev2, junk1;
    logic       all_diff;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist1.delete();
            shist1.delete();
            h2.delete();
            m_o1    = '0;
            m_st1   = '0;
            m_o2    = '0;
            m_st2   = '0;
            m_rise2 = '0;
            m_fall2 = '0;
        end else begin
            hist1.push_back(i1);
            if (hist1.size() > 16) junk4 = hist1.pop_front();
            s_m = (hist1.size() > S1) ? hist1[hist1.size() - 1 - S1] : 4'h0;
            shist1.push_back(s_m);
            if (shist1.size() > 16) junk4 = shist1.pop_front();
            flip = '0;
            if (shist1.size() >= FP1) begin
                for (int k = 0; k < 4; k++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < FP1; j++) begin
                        if (shist1[shist1.size() - 1 - j][k] == m_o1[k]) all_diff = 1'b0;
                    end
                    flip[k] = all_diff;
                end
            end
            r_m   = flip & ~m_o1;
            f_m   = flip & m_o1;
            m_o1  = m_o1 ^ flip;
            m_st1 = (m_st1 & ~clr1) | r_m | f_m;
            if (flip != 4'h0) sb.push_back('{rise: r_m, fall: f_m});

            prev2 = m_o2;
            h2.push_back(i2);
            if (h2.size() > 8) junk1 = h2.pop_front();
            m_o2    = (h2.size() >= 3) ? h2[h2.size() - 3] : 1'b0;
            m_rise2 = m_o2 & ~prev2;
            m_fall2 = ~m_o2 & prev2;
            m_st2   = (m_st2 & ~clr2) | m_rise2;
        end
    end

    // Monitor: sampled 1 time unit after each rising edge.
    ev_t e;
    always @(posedge clk) begin
        #1;
        check("o1_level", {28'd0, o1}, {28'd0, m_o1});
        check("st1_sticky", {28'd0, st1}, {28'd0, m_st1});
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("o1_edge_pulse", {20'd0, rise1, fall1, chg1},
                  {20'd0, e.rise, e.fall, e.rise | e.fall});
        end else begin
            check("o1_no_pulse", {20'd0, rise1, fall1, chg1}, 32'd0);
        end
        check("o2_level", {31'd0, o2}, {31'd0, m_o2});
        check("o2_pulses", {28'd0, rise2, fall2, chg2, st2},
              {28'd0, m_rise2, m_fall2, m_rise2 | m_fall2, m_st2});
    end

    logic saw;

    initial begin
        // Reset with i held high; release on a falling edge.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        i2      = 1'b1;
        for (int ed = 1; ed <= 8; ed++) begin
            @(posedge clk); #1;
            if (ed < 7) check("rel_o_hold", {28'd0, o1}, 32'd0);
            if (ed == 7) check("rel_o_new", {24'd0, o1, rise1}, 32'hFF);
            if (ed == 8) check("rel_rise_once", {28'd0, rise1}, 32'd0);
            if (ed == 2) check("d2_o_before", {31'd0, o2}, 32'd0);
            if (ed == 3) check("d2_o_after3", {30'd0, o2, rise2}, 32'h3);
            if (ed == 4) check("d2_rise_once", {31'd0, rise2}, 32'd0);
        end

        // Channel 0 low, then glitch rejection vs acceptance.
        @(negedge clk); i1 = 4'hE;
        repeat (10) @(negedge clk);
        i1 = 4'hF;
        repeat (3) @(negedge clk);
        i1 = 4'hE;
        saw = 1'b0;
        repeat (12) begin @(posedge clk); #1; saw = saw | rise1[0]; end
        check("glitch3_reject", {30'd0, saw, o1[0]}, 32'd0);
        @(negedge clk); i1 = 4'hF;
        repeat (4) @(negedge clk);
        i1 = 4'hE;
        saw = 1'b0;
        repeat (12) begin @(posedge clk); #1; saw = saw | rise1[0]; end
        check("pulse4_accept", {31'd0, saw}, 32'd1);

        // Clear all sticky flags, then a fall on channel 1.
        @(negedge clk); clr1 = 4'hF;
        @(negedge clk); clr1 = 4'h0; i1 = 4'hC;
        for (int ed = 1; ed <= 7; ed++) begin
            @(posedge clk); #1;
            if (ed == 7) check("fall1_pulse", {20'd0, fall1, chg1, st1}, 32'h222);
        end
        repeat (3) @(posedge clk);
        #1 check("st1_held", {28'd0, st1}, 32'h2);
        @(negedge clk); clr1 = 4'h2;
        @(posedge clk); #1 check("st1_cleared", {28'd0, st1}, 32'h0);

        // Set and clear on the same edge for channel 2.
        @(negedge clk); clr1 = 4'h0; i1 = 4'h8;
        repeat (9) @(negedge clk);
        clr1 = 4'hF;
        @(negedge clk); clr1 = 4'h0; i1 = 4'hC;
        repeat (6) @(posedge clk);
        @(negedge clk); clr1 = 4'h4;
        @(posedge clk); #1 check("set_wins", {24'd0, rise1, st1}, 32'h44);
        @(negedge clk); clr1 = 4'h0;
        @(posedge clk); #1 check("set_wins_held", {28'd0, st1}, 32'h4);

        // Reset mid-count; the count must restart after release.
        @(negedge clk); i1 = 4'h5;
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check("async_reset", {16'd0, o1, rise1, chg1, st1}, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        for (int ed = 1; ed <= 7; ed++) begin
            @(posedge clk); #1;
            if (ed == 6) check("rst_restart_hold", {28'd0, o1}, 32'd0);
            if (ed == 7) check("rst_restart_new", {24'd0, o1, rise1}, 32'h55);
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            i1   = i1 ^ 4'($urandom & $urandom);
            clr1 = 4'($urandom & $urandom & $urandom);
            i2   = ($urandom_range(0, 2) == 0) ? ~i2 : i2;
            clr2 = 1'($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clk); reset_n = 1'b1;
            end
        end

        @(negedge clk); clr1 = 4'h0; clr2 = 1'b0;
        repeat (20) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/synch_filter.md
SYNCH_FILTER -- requirements
Module: synch_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, number of independent channels (1..32).
REQ-002 The block SHALL have parameter STAGES, default 3, synchronizer flop depth per channel (2..4).
REQ-003 The block SHALL have parameter FILTER, default 0, consecutive stable cycles required before an output changes (0..65535; 0 and 1 both mean no filtering).
REQ-004 The block SHALL have parameter RESET_VAL, default all-zero, WIDTH-bit reset/initial value of the sync chain and output.
REQ-005 The block SHALL have parameter EVT_MODE, default 2, sticky event source: 0 rise, 1 fall, 2 either edge.
REQ-006 The block SHALL have port clk, input, 1 bit: the only clock.
REQ-007 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port i, input, WIDTH bits: asynchronous input channels.
REQ-009 The block SHALL have port o, output, WIDTH bits: synchronized, filtered level.
REQ-010 The block SHALL have port rise, output, WIDTH bits: one-cycle pulse per channel on an o 0->1 transition.
REQ-011 The block SHALL have port fall, output, WIDTH bits: one-cycle pulse per channel on an o 1->0 transition.
REQ-012 The block SHALL have port change, output, WIDTH bits: rise | fall.
REQ-013 The block SHALL have port evt_clr, input, WIDTH bits: synchronous per-channel clear of evt_sticky.
REQ-014 The block SHALL have port evt_sticky, output, WIDTH bits: latched event flags.

Function
REQ-015 Each channel SHALL pass i through STAGES cascaded flops; the last flop output is the synced value s.
REQ-016 Each channel SHALL have a counter of width max(1, clog2(FILTER)) that is cleared whenever s == o.
REQ-017 When s != o and the counter equals max(FILTER,1)-1, o SHALL take s on that edge and the counter SHALL clear; otherwise, when s != o, the counter SHALL increment.
REQ-018 Latency from an i change (set up before edge 1) to o SHALL be exactly STAGES + max(FILTER,1) edges when i is held stable.
REQ-019 Any s == o cycle during counting SHALL restart the count, rejecting glitches shorter than max(FILTER,1) synced cycles.
REQ-020 rise, fall and change SHALL be registered and asserted for exactly one cycle, coincident with the first cycle o shows the new value.
REQ-021 Edge detection SHALL work for every WIDTH, per channel independently; channels changing on the same edge SHALL pulse together.
REQ-022 evt_sticky[k] SHALL set on the selected edge(s) per EVT_MODE and clear on evt_clr[k]; a simultaneous set and clear SHALL leave it set.
REQ-023 Counters SHALL never wrap: the update at max(FILTER,1)-1 always clears them.

Reset
REQ-024 reset_n low SHALL immediately (no clock) force sync flops and o to RESET_VAL, counters to 0, and rise/fall/change/evt_sticky to 0.
REQ-025 Reset asserted mid-count SHALL discard the count; after release, filtering SHALL restart from zero.
REQ-026 No edge pulse SHALL occur on reset release; only a later difference between s and o SHALL produce one.

Verification
REQ-027 WIDTH=4, STAGES=3, FILTER=4, RESET_VAL=0: hold i=4'hF through reset release -> o=4'h0 until edge 7 after release, then o=4'hF and rise=4'hF for exactly one cycle.
REQ-028 Same config, o[0]=0: i[0] high for 3 cycles then low -> o[0] stays 0 and rise[0] never asserts; a 4-cycle pulse -> o[0] rises.
REQ-029 EVT_MODE=2, o[1]=1: drop i[1] -> fall[1] and change[1] pulse once, evt_sticky[1]=1 and held until evt_clr[1]=1, then 0 the next cycle.
REQ-030 evt_clr[2]=1 on the same edge as rise[2] -> evt_sticky[2]=1 afterwards.
REQ-031 Assert reset_n=0 while a channel counter=2 -> o=RESET_VAL and counter=0 without a clock edge; after release with i held, o updates 7 edges later.
REQ-032 WIDTH=1, STAGES=2, FILTER=0: toggle i -> o follows after exactly 3 edges, with a rise/fall pulse on each toggle.
